// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 S-array datapath blocks.
//   S_DEPTH / S_ADDR_W / S_DATA_W : geometry of the S RAM
//   chk_state_t                   : state encoding of the S-array init checker
package arc4_pkg;

    localparam int S_DEPTH  = 256;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } chk_state_t;

endpackage

// File: rtl/s_rd_pipe.sv
// Valid/address delay line that tracks reads to a RAM with a fixed read latency.
// Whatever goes in on cycle c comes out on cycle c+LAT, aligned with the RAM's rddata.
//   clk, rst  : rising-edge clock, synchronous active-high reset (flushes the line)
//   in_vld    : a read is being issued this cycle
//   in_addr   : address of that read
//   out_vld   : the read issued LAT cycles ago is returning now
//   out_addr  : address of the returning read
module s_rd_pipe #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LAT-1:0]             vld_pipe;
    logic [LAT-1:0][ADDR_W-1:0] addr_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            addr_pipe[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LAT-1];
    assign out_addr = addr_pipe[LAT-1];

endmodule

// File: rtl/s_init_checker.sv
// Sweeps the S RAM through its read port after initialisation and checks s[i] == i.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   en / rdy   : start handshake; en only counts while rdy=1
//   addr       : RAM read address (holds its last value outside the sweep)
//   rddata     : RAM read data, RD_LAT cycles after addr
//   wren       : RAM write enable, always 0
//   done       : one-cycle pulse at the end of a run
//   pass       : last completed run had no mismatches (0 while a run is in flight)
//   err_addr   : first mismatching address of the last run, 0 if none
//   err_count  : mismatch count of the last run, 0..DEPTH
module s_init_checker
    import arc4_pkg::*;
#(
    parameter int DEPTH  = S_DEPTH,
    parameter int ADDR_W = S_ADDR_W,
    parameter int DATA_W = S_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rddata,
    output logic              wren,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   err_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                CMP_W     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    chk_state_t        state, state_nxt;
    logic              accept;
    logic              tail_vld;
    logic [ADDR_W-1:0] tail_addr;
    logic              mismatch;
    logic [ADDR_W:0]   err_count_nxt;

    assign wren   = 1'b0;
    assign accept = (state == IDLE) && en;

    s_rd_pipe #(
        .LAT    (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (state == READ),
        .in_addr  (addr),
        .out_vld  (tail_vld),
        .out_addr (tail_addr)
    );

    // Both sides zero-extended so the compare is correct for any ADDR_W/DATA_W mix.
    assign mismatch      = tail_vld && (CMP_W'(rddata) != CMP_W'(tail_addr));
    assign err_count_nxt = err_count + {{ADDR_W{1'b0}}, mismatch};

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_nxt = READ;
            end
            READ:  if (addr == LAST_ADDR) state_nxt = DRAIN;
            // The last issued address reaching the tail means every read has been compared.
            DRAIN: if (tail_vld && tail_addr == LAST_ADDR) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            pass      <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;

            if (accept)
                addr <= '0;
            else if (state == READ && addr != LAST_ADDR)
                addr <= addr + ADDR_W'(1);

            if (accept) begin
                pass      <= 1'b0;
                err_addr  <= '0;
                err_count <= '0;
            end else begin
                if (mismatch) begin
                    err_count <= err_count_nxt;
                    // err_count still zero means this is the first mismatch of the run.
                    if (err_count == '0) err_addr <= tail_addr;
                end
                // Use the next count so a mismatch on the final compare is included.
                if (state == DRAIN && state_nxt == DONE)
                    pass <= (err_count_nxt == '0);
            end
        end
    end

endmodule
